// File: rtl/sram_rw_ctrl.sv
// rtl/sram_rw_ctrl.sv - single-port synchronous SRAM with valid/ready request port and self-clear
//
// Purpose
//   Word-addressed scratch memory of DPTH words, DAT bits each. After reset the array is cleared
//   one word per cycle (INIT). After that one request per cycle is accepted (IDLE). Writes honour
//   per-byte enables. Reads return data one cycle after accept. A request whose address is outside
//   the array raises AddrErr and does not touch memory. An out-of-range read returns zero.
//
// Ports
//   Clk       in   1     clock, all state updates on posedge
//   Rst_n     in   1     asynchronous active-low reset
//   ReqValid  in   1     request present this cycle
//   ReqReady  out  1     request accepted when ReqValid & ReqReady
//   ReqWE     in   1     1 = write, 0 = read
//   Addr      in   ADR   word address
//   dataIn    in   DAT   write data
//   ByteEn    in   BEW   per-byte write mask, bit i covers dataIn[8i+7:8i]
//   RspValid  out  1     one-cycle pulse per accepted read
//   dataOut   out  DAT   read data, holds last value when RspValid=0
//   AddrErr   out  1     one-cycle pulse for an accepted request with Addr >= DPTH
//   InitBusy  out  1     self-clear in progress
//
// Configuration
//   SRAM_OUT_REG_EN  adds one output register stage after the read path: RspValid, dataOut and
//                    AddrErr arrive one cycle later. Throughput is unchanged.

module sram_rw_ctrl #(
    parameter int ADR  = 8,
    parameter int DAT  = 32,
    parameter int DPTH = 192
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic                ReqWE,
    input  logic [ADR-1:0]      Addr,
    input  logic [DAT-1:0]      dataIn,
    input  logic [DAT/8-1:0]    ByteEn,
    output logic                RspValid,
    output logic [DAT-1:0]      dataOut,
    output logic                AddrErr,
    output logic                InitBusy
);

    localparam int BEW = DAT / 8;

    // Depth widened by one bit so that DPTH == 2**ADR still compares correctly.
    localparam logic [ADR:0]   DPTH_W   = (ADR + 1)'(DPTH);
    localparam logic [ADR-1:0] LAST_IDX = ADR'(DPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADR-1:0]     r_init_ptr;

    logic               w_ready;
    logic               w_init_busy;
    logic               w_init_last;
    logic               w_accept;
    logic               w_in_range;
    logic               w_wr_en;

    logic [DAT-1:0]     r_mem [DPTH];

    logic               r_rsp_valid;
    logic [DAT-1:0]     r_data_out;
    logic               r_addr_err;

    //------------------------------------------------------------------
    // Request qualification
    //------------------------------------------------------------------
    assign w_in_range  = ({1'b0, Addr} < DPTH_W);
    assign w_accept    = ReqValid & w_ready;
    assign w_wr_en     = w_accept & ReqWE & w_in_range;
    assign w_init_last = (r_init_ptr == LAST_IDX);

    //------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //------------------------------------------------------------------
    // FSM: next state and state decodes
    //------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_init_busy = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_busy = 1'b1;
                if (w_init_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_ready = 1'b1;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Self-clear pointer; parked at 0 once the last word is cleared so a
    // later reset always restarts from word 0.
    //------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_init_ptr <= '0;
        end else if (r_state == ST_INIT) begin
            if (w_init_last) begin
                r_init_ptr <= '0;
            end else begin
                r_init_ptr <= r_init_ptr + 1'b1;
            end
        end
    end

    //------------------------------------------------------------------
    // Storage array. Not reset: its contents are defined by the INIT sweep.
    //------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_init_ptr] <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < BEW; i++) begin
                if (ByteEn[i]) begin
                    r_mem[Addr][8*i +: 8] <= dataIn[8*i +: 8];
                end
            end
        end
    end

    //------------------------------------------------------------------
    // Read response stage. An out-of-range read still produces a response
    // carrying zero, so a requester counting responses never stalls.
    //------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rsp_valid <= 1'b0;
            r_data_out  <= '0;
            r_addr_err  <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept & ~ReqWE;
            r_addr_err  <= w_accept & ~w_in_range;
            if (w_accept && !ReqWE) begin
                r_data_out <= w_in_range ? r_mem[Addr] : '0;
            end
        end
    end

`ifdef SRAM_OUT_REG_EN
    //------------------------------------------------------------------
    // Optional output register stage. dataOut copies the first stage every
    // cycle; the first stage already holds between responses.
    //------------------------------------------------------------------
    logic               r_rsp_valid_q;
    logic [DAT-1:0]     r_data_out_q;
    logic               r_addr_err_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rsp_valid_q <= 1'b0;
            r_data_out_q  <= '0;
            r_addr_err_q  <= 1'b0;
        end else begin
            r_rsp_valid_q <= r_rsp_valid;
            r_data_out_q  <= r_data_out;
            r_addr_err_q  <= r_addr_err;
        end
    end

    assign RspValid = r_rsp_valid_q;
    assign dataOut  = r_data_out_q;
    assign AddrErr  = r_addr_err_q;
`else
    assign RspValid = r_rsp_valid;
    assign dataOut  = r_data_out;
    assign AddrErr  = r_addr_err;
`endif

    assign ReqReady = w_ready;
    assign InitBusy = w_init_busy;

endmodule
